fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-word fetch stage.
- Keeps a running fetch PC and issues sequential word requests to a variable-latency, in-order instruction memory port.
- Buffers returned instructions, each paired with its PC, in a DEPTH-entry queue.
- Presents the queue head to decode over a valid/ready handshake.
- Supports branch/jump redirect that flushes the queue and discards stale in-flight responses.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- DEPTH, 4, instruction queue entries; also the cap on outstanding memory requests (power of two, >=2).
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts request this edge.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid (in request order).
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  control-flow redirect from execute.
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  PC of head instruction.
- out_instr  out  XLEN  head instruction.

Behaviour:
- Internal state:
  - fetch_pc: next address to request.
  - rsp_pc: PC of next expected kept response.
  - outstanding count, 0..DEPTH.
  - drop_cnt: stale responses still to discard.
  - queue with count, 0..DEPTH.
- Reset (rst=0, async, any time including mid-stream):
  - fetch_pc = rsp_pc = RESET_PC; all counts = 0.
  - imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = 0.
- Request issue:
  - imem_req_valid is combinational: 1 when (count + outstanding - drop_cnt) < DEPTH, outstanding < DEPTH, redirect_valid = 0, and not in reset.
  - imem_req_addr = fetch_pc.
  - Address and valid hold stable while imem_req_ready = 0.
  - On an edge with valid & ready: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
- Response:
  - On an edge with imem_rsp_valid: outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise: push {rsp_pc, data} into the queue and rsp_pc += 4.
  - The credit rule guarantees a push never finds the queue full. Responses with outstanding = 0 are a protocol violation; the block ignores them.
- Output:
  - out_valid = (count != 0); out_pc/out_instr = head entry, combinational from the queue.
  - Pop on valid & ready. First instruction is visible 1 cycle after the response edge.
  - Same-edge push and pop is legal at any count, including full or empty+push (no bypass: a word pushed at an empty queue appears next cycle).
- Redirect (edge with redirect_valid = 1), highest priority:
  - Queue cleared (count = 0; any pop that edge is a don't-care).
  - fetch_pc = rsp_pc = redirect_pc with bits [1:0] forced to 0.
  - No request issued that cycle.
  - drop_cnt = outstanding - (imem_rsp_valid ? 1 : 0). Any response arriving on the redirect edge is also discarded.
  - out_valid = 0 the following cycle.
  - The first request to the new target is issued the cycle after redirect.
  - A redirect while drop_cnt > 0 overwrites drop_cnt by the same formula, which accounts for all in-flight requests.
- Arithmetic: all PC adds are XLEN-bit and wrap. Counters are clog2(DEPTH)+1 bits.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response, out_ready=1 -> out_pc stream 0x0, 0x4, 0x8, 0xC, ...; each out_instr matches the memory image; sustained 1 instr/cycle after warm-up.
- out_ready=0 from reset, DEPTH=4 -> exactly 4 requests (0x0..0xC); imem_req_valid then stays 0; count = 4. Releasing out_ready for 1 cycle pops PC 0x0 and allows exactly one new request, to 0x10.
- 3-cycle response latency, 2 requests outstanding, redirect_pc=0x100 -> both stale responses dropped; next out_pc = 0x100 with the instruction from 0x100; no 0x8/0xC entry ever appears.
- redirect_pc=0x103 -> imem_req_addr=0x100 the next cycle; out_pc=0x100.
- imem_req_ready held 0 for 5 cycles -> imem_req_addr stable at its value and fetch_pc not advanced; no responses expected.
- rst driven low mid-cycle with queue half full and requests outstanding -> outputs clear immediately without a clock edge; after release, fetch restarts at RESET_PC and late responses from before reset are not required to be handled (memory is reset too).

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Sequential instruction prefetcher. It keeps a running fetch PC and issues
//   word requests to an in-order, variable-latency instruction memory. Each
//   returned word is buffered together with its PC in a DEPTH-entry queue, and
//   the queue head is presented to decode. A redirect flushes the queue, retargets
//   fetch and discards every response still in flight.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr request channel to instruction memory
//   imem_rsp_valid/data       in-order response channel
//   redirect_valid/pc         control-flow redirect from execute
//   out_valid/ready/pc/instr  queue head towards decode
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW1-1:0] DEPTH_W = CW1'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [CW1-1:0] credit_used;
    logic           req_fire;
    logic           rsp_fire;
    logic           push;
    logic           pop;

    // Queue slots already claimed: buffered words plus responses that will be
    // kept. Stale (to-be-dropped) responses never consume a slot.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, drop_q};

    assign imem_req_valid = rst & ~redirect_valid & (outst_q < DEPTH_C)
                          & (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push       = 1'b0;
        pop        = out_valid & out_ready;
        req_fire   = imem_req_valid & imem_req_ready;
        // A response with nothing outstanding is a protocol error; ignore it.
        rsp_fire   = imem_rsp_valid & (outst_q != '0);
        outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight after this edge is stale.
            drop_d     = outst_q - CW'(rsp_fire);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            pop        = 1'b0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: reads are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= rsp_pc_q;
            instr_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit
//   Self-checking bench for fetch_prefetch_unit: a directed vector table, an
//   in-order memory plus reference model for random and scripted sequences, and
//   an asynchronous mid-cycle reset check.
module tb_fetch_prefetch_unit;

    localparam int unsigned   XLEN     = 32;
    localparam int unsigned   DEPTH    = 4;
    localparam logic [31:0]   RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_valid;
    logic        out_ready      = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_prefetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // In-flight requests in issue order; a redirect marks them all stale.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          due;
    } infl_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    infl_t       infl[$];
    ent_t        outq[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          last_due;
    int          lat_min = 1;
    int          lat_max = 1;

    bit          last_rv;
    bit          last_ov;
    logic [31:0] last_addr;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    bit          saw_stale;

    task automatic model_clear();
        infl.delete();
        outq.delete();
        m_fetch_pc = RESET_PC;
        cyc        = 0;
        last_due   = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        rst            = 1'b0;
        model_clear();
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model
    // to what the following rising edge must produce.
    task automatic cycle(input bit rrdy, input bit ordy, input bit redir,
                         input logic [31:0] rpc);
        bit    rsp;
        bit    exp_rv;
        bit    do_pop;
        int    kept;
        int    due;
        infl_t e;
        ent_t  d;
        @(negedge clk);
        imem_req_ready = rrdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp            = (infl.size() > 0) && (infl[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? img(infl[0].addr) : $urandom;
        #1;
        kept = 0;
        foreach (infl[i]) if (!infl[i].stale) kept++;
        exp_rv = !redir && (infl.size() < DEPTH) && ((outq.size() + kept) < DEPTH);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, (outq.size() != 0)});
        if (outq.size() != 0) begin
            check("out_pc", out_pc, outq[0].pc);
            check("out_instr", out_instr, outq[0].instr);
        end
        last_rv    = imem_req_valid;
        last_ov    = out_valid;
        last_addr  = imem_req_addr;
        last_pc    = out_pc;
        last_instr = out_instr;
        if (out_valid && (out_pc == 32'h8 || out_pc == 32'hC)) saw_stale = 1'b1;

        do_pop = !redir && (outq.size() > 0) && ordy;
        if (do_pop) void'(outq.pop_front());
        if (rsp) begin
            e = infl.pop_front();
            if (!redir && !e.stale) begin
                d.pc    = e.addr;
                d.instr = img(e.addr);
                outq.push_back(d);
            end
        end
        if (redir) begin
            outq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_fetch_pc = {rpc[31:2], 2'b00};
        end else if (exp_rv && rrdy) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            e.addr  = m_fetch_pc;
            e.stale = 1'b0;
            e.due   = due;
            infl.push_back(e);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rrdy;
        bit          rsp;
        logic [31:0] rsp_addr;
        bit          redir;
        logic [31:0] rpc;
        bit          ordy;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_ov;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit rrdy, input bit rsp, input logic [31:0] rsp_addr,
                       input bit redir, input logic [31:0] rpc, input bit ordy,
                       input bit e_rv, input logic [31:0] e_addr,
                       input bit e_ov, input logic [31:0] e_pc);
        vec_t v;
        v.rrdy = rrdy; v.rsp = rsp; v.rsp_addr = rsp_addr; v.redir = redir;
        v.rpc = rpc; v.ordy = ordy; v.e_rv = e_rv; v.e_addr = e_addr;
        v.e_ov = e_ov; v.e_pc = e_pc;
        vq.push_back(v);
    endtask

    initial begin
        int ov_cnt;
        int waited;

        // Fill to DEPTH with decode stalled, single pop, redirect to an
        // unaligned target, then five cycles of request back-pressure.
        //   rrdy rsp addr      rd pc        ordy rv addr      ov pc
        add(1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h0,   0, 32'h0);
        add(1, 1, 32'h0,    0, 32'h0,   0, 1, 32'h4,   0, 32'h0);
        add(1, 1, 32'h4,    0, 32'h0,   0, 1, 32'h8,   1, 32'h0);
        add(1, 1, 32'h8,    0, 32'h0,   0, 1, 32'hC,   1, 32'h0);
        add(1, 1, 32'hC,    0, 32'h0,   0, 0, 32'h0,   1, 32'h0);
        add(1, 0, 32'h0,    0, 32'h0,   0, 0, 32'h0,   1, 32'h0);
        add(1, 0, 32'h0,    0, 32'h0,   1, 0, 32'h0,   1, 32'h0);
        add(1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h10,  1, 32'h4);
        add(1, 1, 32'h10,   0, 32'h0,   0, 0, 32'h0,   1, 32'h4);
        add(1, 0, 32'h0,    0, 32'h0,   0, 0, 32'h0,   1, 32'h4);
        add(1, 0, 32'h0,    1, 32'h103, 0, 0, 32'h0,   1, 32'h4);
        add(1, 0, 32'h0,    0, 32'h0,   0, 1, 32'h100, 0, 32'h0);
        add(1, 1, 32'h100,  0, 32'h0,   0, 1, 32'h104, 0, 32'h0);
        add(0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
        add(0, 1, 32'h104,  0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,    0, 32'h0,   1, 1, 32'h108, 1, 32'h100);
        add(0, 0, 32'h0,    0, 32'h0,   1, 1, 32'h108, 1, 32'h104);
        add(0, 0, 32'h0,    0, 32'h0,   0, 1, 32'h108, 0, 32'h0);

        do_reset();
        foreach (vq[i]) begin
            @(negedge clk);
            imem_req_ready = vq[i].rrdy;
            imem_rsp_valid = vq[i].rsp;
            imem_rsp_data  = img(vq[i].rsp_addr);
            redirect_valid = vq[i].redir;
            redirect_pc    = vq[i].rpc;
            out_ready      = vq[i].ordy;
            #1;
            check($sformatf("vec%0d_req_valid", i), {31'b0, imem_req_valid},
                  {31'b0, vq[i].e_rv});
            if (vq[i].e_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vq[i].e_addr);
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vq[i].e_ov});
            if (vq[i].e_ov) begin
                check($sformatf("vec%0d_out_pc", i), out_pc, vq[i].e_pc);
                check($sformatf("vec%0d_out_instr", i), out_instr, img(vq[i].e_pc));
            end
        end

        // Sustained throughput with a 1-cycle memory and decode always ready.
        do_reset();
        lat_min = 1; lat_max = 1;
        ov_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0);
            if (i >= 12 && last_ov) ov_cnt++;
        end
        check("sustained_out_valid_cycles", ov_cnt, 32'd12);

        // Redirect with two requests in flight and one responding on the
        // redirect edge: neither 0x8 nor 0xC may ever reach decode.
        do_reset();
        lat_min = 3; lat_max = 3;
        saw_stale = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("pre_redirect_inflight", infl.size(), 32'd2);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        waited = 0;
        do begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            waited++;
        end while (!last_ov && waited < 20);
        check("redirect_first_out_valid", {31'b0, last_ov}, 32'd1);
        check("redirect_first_pc", last_pc, 32'h100);
        check("redirect_first_instr", last_instr, img(32'h100));
        check("stale_never_seen", {31'b0, saw_stale}, 32'd0);

        // Random traffic against the reference model, including wrap-around.
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            bit          redir;
            logic [31:0] rpc;
            redir = ($urandom_range(29, 0) == 0);
            rpc   = $urandom;
            if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            cycle(($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 7), redir, rpc);
        end

        // Asynchronous reset in the middle of a cycle with a part-full queue.
        do_reset();
        lat_min = 2; lat_max = 3;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("pre_rst_out_valid", {31'b0, last_ov}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_out_pc", out_pc, 32'd0);
        check("async_rst_out_instr", out_instr, 32'd0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("restart_req_valid", {31'b0, last_rv}, 32'd1);
        check("restart_req_addr", last_addr, RESET_PC);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
